// File: rtl/piso_tx_if.sv
// piso_tx_if: load handshake bundle (d_in, load_valid from upstream master; load_ready from piso_tx slave)
interface piso_tx_if #(parameter int WIDTH = 4) ();
  logic [WIDTH-1:0] d_in;
  logic             load_valid;
  logic             load_ready;
  modport master (output d_in, load_valid, input load_ready);
  modport slave  (input d_in, load_valid, output load_ready);
endinterface

// File: rtl/piso_tx.sv
// piso_tx: framed serializer (start, LSB-first data, optional even parity, stop); ports clk, rst_ (sync active-high), ld (d_in/load_valid/load_ready), s_out, busy, done
module piso_tx #(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 0
) (
  input  logic       clk,
  input  logic       rst_,
  piso_tx_if.slave   ld,
  output logic       s_out,
  output logic       busy,
  output logic       done
);
  localparam int BW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] BLAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] ILAST = IW'(WIDTH - 1);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4;
  logic [2:0]       state;
  logic [BW-1:0]    baud;
  logic [IW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shreg, nxt;
  logic             par, wrap;
  assign ld.load_ready = state == IDLE;
  assign wrap = baud == BLAST;
  assign nxt = shreg >> 1;
  always_ff @(posedge clk) begin
    if (rst_) begin
      state   <= IDLE;
      s_out   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      baud    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE) baud <= wrap ? '0 : baud + 1'b1;
      case (state)
        IDLE: if (ld.load_valid) begin
          shreg   <= ld.d_in;
          par     <= ^ld.d_in;
          bit_cnt <= '0;
          baud    <= '0;
          state   <= START;
          s_out   <= 1'b0;
          busy    <= 1'b1;
        end
        START: if (wrap) begin
          state <= DATA;
          s_out <= shreg[0];
        end
        DATA: if (wrap) begin
          shreg   <= nxt;
          bit_cnt <= bit_cnt == ILAST ? '0 : bit_cnt + 1'b1;
          if (bit_cnt == ILAST) begin
            state <= PARITY_EN != 0 ? PARITY : STOP;
            s_out <= PARITY_EN != 0 ? par : 1'b1;
          end else
            s_out <= nxt[0];
        end
        PARITY: if (wrap) begin
          state <= STOP;
          s_out <= 1'b1;
        end
        STOP: if (wrap) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: directed checks of piso_tx (CPB=2 no parity, CPB=1 with parity)
module tb_piso_tx;
  logic clk = 1'b0, rst_ = 1'b1;
  logic a_s, a_busy, a_done, b_s, b_busy, b_done;
  int checks = 0, errors = 0, cyc = 0, t1, t2;
  piso_tx_if #(.WIDTH(4)) a_if ();
  piso_tx_if #(.WIDTH(4)) b_if ();
  piso_tx #(.WIDTH(4), .CLKS_PER_BIT(2), .PARITY_EN(0)) dut_a (
    .clk(clk), .rst_(rst_), .ld(a_if.slave), .s_out(a_s), .busy(a_busy), .done(a_done));
  piso_tx #(.WIDTH(4), .CLKS_PER_BIT(1), .PARITY_EN(1)) dut_b (
    .clk(clk), .rst_(rst_), .ld(b_if.slave), .s_out(b_s), .busy(b_busy), .done(b_done));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge right after the accept edge; checks every line cycle then the done cycle.
  task automatic watch(input bit sel, input logic [7:0] bits, input int nb, output int t_done);
    int cpb;
    cpb = sel ? 1 : 2;
    for (int k = 0; k < nb * cpb; k++) begin
      chk("line", sel ? b_s : a_s, 32'(bits[k / cpb]));
      chk("busy_frame", sel ? b_busy : a_busy, 1);
      chk("done_early", sel ? b_done : a_done, 0);
      @(negedge clk);
    end
    t_done = cyc;
    chk("done_pulse", sel ? b_done : a_done, 1);
    chk("busy_end", sel ? b_busy : a_busy, 0);
    chk("line_idle", sel ? b_s : a_s, 1);
    chk("ready_end", sel ? b_if.load_ready : a_if.load_ready, 1);
  endtask

  task automatic load(input bit sel, input logic [3:0] d);
    if (sel) begin b_if.d_in = d; b_if.load_valid = 1'b1; end
    else begin a_if.d_in = d; a_if.load_valid = 1'b1; end
    @(negedge clk);
    a_if.load_valid = 1'b0;
    b_if.load_valid = 1'b0;
  endtask

  initial begin
    a_if.d_in = '0; a_if.load_valid = 1'b0;
    b_if.d_in = '0; b_if.load_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_s_a", a_s, 1);
    chk("rst_busy_a", a_busy, 0);
    chk("rst_done_a", a_done, 0);
    chk("rst_s_b", b_s, 1);
    rst_ = 1'b0;
    @(negedge clk);
    chk("rst_ready_a", a_if.load_ready, 1);
    chk("rst_ready_b", b_if.load_ready, 1);
    // 0111, CPB=2: 0,1,1,1,0,1
    load(0, 4'b0111);
    watch(0, 8'b0010_1110, 6, t1);
    @(negedge clk);
    chk("done_once", a_done, 0);
    // parity, CPB=1: 1011 -> 0,1,1,0,1,p=1,1
    load(1, 4'b1011);
    watch(1, 8'b0111_0110, 7, t1);
    // 1001 -> 0,1,0,0,1,p=0,1
    load(1, 4'b1001);
    watch(1, 8'b0101_0010, 7, t1);
    // back-to-back with load_valid held
    @(negedge clk);
    a_if.d_in = 4'b1001; a_if.load_valid = 1'b1;
    @(negedge clk);
    a_if.d_in = 4'b1111;
    watch(0, 8'b0011_0010, 6, t1);
    @(negedge clk);
    a_if.load_valid = 1'b0;
    watch(0, 8'b0011_1110, 6, t2);
    chk("done_gap", 32'(t2 - t1), 13);
    @(negedge clk);
    chk("no_queue", a_busy, 0);
    // d_in change mid-frame ignored
    load(0, 4'b1111);
    a_if.d_in = 4'b0001;
    watch(0, 8'b0011_1110, 6, t1);
    // reset during data bit 2 (cycles 6,7 after accept)
    @(negedge clk);
    load(0, 4'b1011);
    repeat (6) @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);
    rst_ = 1'b0;
    chk("abort_s", a_s, 1);
    chk("abort_busy", a_busy, 0);
    chk("abort_ready", a_if.load_ready, 1);
    chk("abort_done", a_done, 0);
    t1 = 0;
    repeat (12) begin
      @(negedge clk);
      t1 += int'(a_done);
    end
    chk("abort_no_done", t1, 0);
    load(0, 4'b0111);
    watch(0, 8'b0010_1110, 6, t1);
    // load_valid during reset is not accepted
    @(negedge clk);
    rst_ = 1'b1; a_if.d_in = 4'b0000; a_if.load_valid = 1'b1;
    @(negedge clk);
    rst_ = 1'b0; a_if.load_valid = 1'b0;
    chk("rstload_s", a_s, 1);
    chk("rstload_busy", a_busy, 0);
    @(negedge clk);
    chk("rstload_s2", a_s, 1);
    chk("rstload_busy2", a_busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
